// File: rtl/encoder_fec_pkg.sv
// Shared widths and types for the FEC encoder chain.
package encoder_fec_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned ENTRIES_BUFFER   = 1024;
  localparam int unsigned FIFO_COUNT_WIDTH = $clog2(ENTRIES_BUFFER) + 1;

  typedef logic [DATA_WIDTH-1:0]       message_data_t;
  typedef logic [FIFO_COUNT_WIDTH-1:0] fifo_count_t;

endpackage

// File: rtl/fec_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module fec_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fec_message_fifo.sv
// Synchronous message FIFO with occupancy count, almost-full/empty thresholds
// and sticky overflow/underflow flags.
module fec_message_fifo #(
  parameter int unsigned DATA_WIDTH    = encoder_fec_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH         = encoder_fec_pkg::ENTRIES_BUFFER,
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clear_err,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, afull_q, empty_q, aempty_q;
  logic                  rd_valid_q, data_seen_q;
  logic                  ovf_q, udf_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      rd_valid_q  <= 1'b0;
      data_seen_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      full_q      <= (count_d == CW'(DEPTH));
      afull_q     <= (count_d >= CW'(AFULL_THRESH));
      empty_q     <= (count_d == '0);
      aempty_q    <= (count_d <= CW'(AEMPTY_THRESH));
      rd_valid_q  <= rd_acc;
      data_seen_q <= data_seen_q | rd_acc;
      // A new error event wins over a simultaneous clear.
      ovf_q       <= (wr_en && full_q)  || (ovf_q && !clear_err);
      udf_q       <= (rd_en && empty_q) || (udf_q && !clear_err);
    end
  end

  fec_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_acc && !rst),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // RAM output register has no reset; mask it until the first read since reset.
  assign rd_data      = data_seen_q ? ram_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fec_message_fifo.sv
// Scoreboard bench for fec_message_fifo against a queue-based reference model.
module tb_fec_message_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AF    = DEPTH - 4;
  localparam int unsigned AE    = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clear_err;
  logic [DW-1:0] wr_data;
  logic          full, almost_full, rd_valid, empty, almost_empty;
  logic          overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fec_message_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .clear_err    (clear_err),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;
  bit            movf = 1'b0, mudf = 1'b0;
  bit            started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [DW-1:0] d,
                      input bit rd, input bit clr);
    bit wacc, racc, was_full, was_empty;
    rst = r; wr_en = w; wr_data = d; rd_en = rd; clear_err = clr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      exp_q.delete();
      movf = 1'b0; mudf = 1'b0; last_rd = '0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      wacc = w && !was_full;
      racc = rd && !was_empty;
      movf = (w && was_full)   ? 1'b1 : (clr ? 1'b0 : movf);
      mudf = (rd && was_empty) ? 1'b1 : (clr ? 1'b0 : mudf);
      if (racc) begin
        last_rd = mq.pop_front();
        exp_q.push_back(last_rd);
      end
      if (wacc) mq.push_back(d);
    end
    @(negedge clk);
    #1;
    check("count",        64'(count),        64'(mq.size()));
    check("empty",        64'(empty),        64'(mq.size() == 0));
    check("full",         64'(full),         64'(mq.size() == DEPTH));
    check("almost_full",  64'(almost_full),  64'(mq.size() >= AF));
    check("almost_empty", 64'(almost_empty), 64'(mq.size() <= AE));
    check("overflow",     64'(overflow),     64'(movf));
    check("underflow",    64'(underflow),    64'(mudf));
    check("rd_valid_missing", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) check("spurious_rd_valid", 64'd1, 64'd0);
        else                   check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end else begin
        check("rd_valid_low", 64'(rd_valid), 64'd0);
        check("rd_data_hold", 64'(rd_data), 64'(last_rd));
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    started = 1'b1;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b1, 1'b0);   // full: read wins, write rejected
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    step(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);  // empty: write only
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++)   step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, $urandom, 1'b1, 1'b0);

    for (int i = 0; i < 490; i++)  step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)   step(1'b0, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 2500; i++) begin
        bit w, rd, clr, r;
        w   = ($urandom_range(0, 99) < (ph == 0 ? 75 : 30));
        rd  = ($urandom_range(0, 99) < (ph == 0 ? 30 : 75));
        clr = ($urandom_range(0, 99) < 3);
        r   = ($urandom_range(0, 999) < 2);
        step(r, w, $urandom, rd, clr);
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
